fp_to_twos: RTL

Decoder for the 8-bit floating-point format produced by the lab2 converter path. The format is {S, E[2:0], F[3:0]}, with value = (-1)^S * F * 2^E. The block expands one such value back to 12-bit two's complement. It uses an iterative shifter (one bit per clock) and valid/ready handshakes on both sides. It sits downstream of the converter and is used for round-trip checking and display.

---
 rtl/fp_to_twos.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fp_to_twos.sv
// fp_to_twos: expands an 8-bit {S, E[2:0], F[3:0]} value (value = (-1)^S * F * 2^E)
// into an OUT_W-bit two's-complement word. The magnitude is built with an iterative
// shifter that moves one bit per clock. Both sides use valid/ready handshakes, and
// only one conversion is in flight at a time.
//
// Optional build macro FPDEC_COUNT_EN adds an 8-bit conv_count output. It counts
// completed output handshakes and wraps from 255 to 0.
//
// OUT_W must be at least 12 so that the largest magnitude (15 * 2^7 = 1920) and its
// negation fit without overflow.

module fp_to_twos #(
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
`ifdef FPDEC_COUNT_EN
  ,
  output logic [7:0]       conv_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

  state_e           state_q,     state_d;
  logic [OUT_W-1:0] mag_q,       mag_d;
  logic [2:0]       cnt_q,       cnt_d;
  logic             sign_q,      sign_d;
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;

  // Input fields, named for readability.
  logic       in_sign;
  logic [2:0] in_exp;
  logic [3:0] in_frac;

  assign in_sign = in_data[7];
  assign in_exp  = in_data[6:4];
  assign in_frac = in_data[3:0];

  // Input is accepted only while idle, so in_valid is ignored in every other state.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next-state and datapath update for the decode sequence.
  always_comb begin
    // NOTE: every signal written here is given a default first. That way no path
    // leaves a signal unassigned, and no latch is inferred.
    state_d     = state_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          cnt_d   = in_exp;
          mag_d   = {{(OUT_W-4){1'b0}}, in_frac};
          // A zero exponent needs no shifting, so go straight to sign application.
          state_d = (in_exp != 3'd0) ? SHIFT : SIGN;
        end
      end

      SHIFT: begin
        // One doubling per clock. The count is never 0 while in this state.
        mag_d = mag_q << 1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = SIGN;
        end
      end

      SIGN: begin
        // Negation wraps at OUT_W bits. Negative zero therefore comes out as 0.
        out_data_d  = sign_q ? (~mag_q + ONE) : mag_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        // Hold the result until the consumer takes it. out_data keeps its last value.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset is asynchronous and discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state is written with non-blocking assignments. All registers
      // then update together from values sampled before the edge.
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef FPDEC_COUNT_EN
  logic [7:0] conv_count_q;

  // Count completed output handshakes. The count wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_count_q <= 8'd0;
    end else if (out_valid_q && out_ready) begin
      conv_count_q <= conv_count_q + 8'd1;
    end
  end

  assign conv_count = conv_count_q;
`endif

endmodule
